burst_ram_arbiter: RTL

//  Shares one BurstRAM port between two burst masters (m0: instruction cache, m1: data cache).

---
 rtl/burst_ram_arbiter_pkg.sv | 23 ++
 rtl/burst_ram_arbiter_pick.sv | 37 +++
 rtl/burst_ram_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/burst_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : burst_ram_arbiter_pkg
// Brief    : Shared types and constants for the two-master BurstRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package burst_ram_arbiter_pkg;

  // Arbiter sequencing states; width fixed so the encoding is stable in netlists
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_WAIT  = 2'd2
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Index of a burst master: 0 = instruction cache, 1 = data cache
  typedef logic owner_t;

endpackage
`default_nettype wire

// File: rtl/burst_ram_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module   : burst_ram_arbiter_pick
// Brief    : Combinational 2-input picker. Round-robin on a tie by default;
//            with BURST_RAM_ARBITER_FIXED_PRIORITY_EN defined m0 always wins.
// Revision : 1.0 - initial release
// ============================================================================
module burst_ram_arbiter_pick
  import burst_ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     rr_last,
  output logic       grant_valid,
  output owner_t     grant_ix
);

`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
  // History is irrelevant when m0 always has priority
  logic w_unused_rr;
  assign w_unused_rr = rr_last;

  // Fixed priority: m0 whenever it asks, otherwise m1
  always_comb begin
    grant_valid = |req;
    grant_ix    = req[0] ? 1'b0 : 1'b1;
  end
`else
  // Round-robin: a lone requester wins; on a tie the master not served last wins
  always_comb begin
    grant_valid = |req;
    if (req == 2'b11) grant_ix = ~rr_last;
    else              grant_ix = req[1];
  end
`endif

endmodule
`default_nettype wire

// File: rtl/burst_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : burst_ram_arbiter
// Brief    : Shares one BurstRAM port between two burst masters, granting one
//            whole burst at a time with zero added command latency.
//            Optional macro: BURST_RAM_ARBITER_FIXED_PRIORITY_EN (m0 wins ties).
// Revision : 1.0 - initial release
// ============================================================================
module burst_ram_arbiter
  import burst_ram_arbiter_pkg::*;
#(
  parameter int DEPTH_BITWIDTH = 4,
  parameter int BURST_COUNT    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m0_cmd,
  input  logic                      m0_cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0] m0_addr,
  input  logic [63:0]               m0_wr_data,
  input  logic [7:0]                m0_data_mask,
  output logic [63:0]               m0_rd_data,
  output logic                      m0_rd_data_valid,
  output logic                      m0_busy,
  input  logic                      m1_cmd,
  input  logic                      m1_cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0] m1_addr,
  input  logic [63:0]               m1_wr_data,
  input  logic [7:0]                m1_data_mask,
  output logic [63:0]               m1_rd_data,
  output logic                      m1_rd_data_valid,
  output logic                      m1_busy,
  output logic                      br_cmd,
  output logic                      br_cmd_en,
  output logic [DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]               br_wr_data,
  output logic [7:0]                br_data_mask,
  input  logic [63:0]               br_rd_data,
  input  logic                      br_rd_data_valid,
  input  logic                      br_init_calib,
  input  logic                      br_busy
);

  localparam int                CNT_W       = $clog2(BURST_COUNT) + 1;
  localparam logic [CNT_W-1:0]  c_last_beat = CNT_W'(BURST_COUNT - 1);
  localparam logic [CNT_W-1:0]  c_one       = CNT_W'(1);

  state_t           r_state,    w_state_nxt;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
  owner_t           r_owner,    w_owner_nxt;
  owner_t           r_rr_last,  w_rr_last_nxt;

  logic   w_grant_valid;
  owner_t w_grant_ix;
  logic   w_ready;
  logic   w_accept;
  owner_t w_sel;

  burst_ram_arbiter_pick u_pick (
    .req         ({m1_cmd_en, m0_cmd_en}),
    .rr_last     (r_rr_last),
    .grant_valid (w_grant_valid),
    .grant_ix    (w_grant_ix)
  );

  // A new burst can start only from IDLE with a calibrated, non-busy RAM
  assign w_ready  = !rst && br_init_calib && !br_busy && (r_state == IDLE);
  assign w_accept = w_ready && w_grant_valid;
  // The IDLE winner drives the RAM; otherwise the current/last owner keeps it
  assign w_sel    = ((r_state == IDLE) && w_grant_valid) ? w_grant_ix : r_owner;

  // The loser of this cycle's pick is busy even when the RAM is free
  assign m0_busy = !w_ready || (w_grant_valid && (w_grant_ix == 1'b1));
  assign m1_busy = !w_ready || (w_grant_valid && (w_grant_ix == 1'b0));

  assign m0_rd_data = br_rd_data;
  assign m1_rd_data = br_rd_data;

  // State register; reset abandons any partial burst immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
      r_owner    <= 1'b0;
      r_rr_last  <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_last  <= w_rr_last_nxt;
    end
  end

  // Next-state logic plus RAM-side muxing and read-valid routing
  always_comb begin
    w_state_nxt      = r_state;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_owner_nxt      = r_owner;
    w_rr_last_nxt    = r_rr_last;
    br_cmd_en        = 1'b0;
    br_cmd           = w_sel ? m1_cmd       : m0_cmd;
    br_addr          = w_sel ? m1_addr      : m0_addr;
    br_wr_data       = w_sel ? m1_wr_data   : m0_wr_data;
    br_data_mask     = w_sel ? m1_data_mask : m0_data_mask;
    m0_rd_data_valid = 1'b0;
    m1_rd_data_valid = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          br_cmd_en     = 1'b1;
          w_owner_nxt   = w_grant_ix;
          w_rr_last_nxt = w_grant_ix;
          // The accept cycle already carries write beat 0
          if (br_cmd == CMD_WRITE) begin
            w_state_nxt    = WR_BURST;
            w_beat_cnt_nxt = c_one;
          end else begin
            w_state_nxt    = RD_WAIT;
            w_beat_cnt_nxt = '0;
          end
        end
      end
      WR_BURST: begin
        if (r_beat_cnt == c_last_beat) w_state_nxt    = IDLE;
        else                           w_beat_cnt_nxt = r_beat_cnt + c_one;
      end
      RD_WAIT: begin
        if (br_rd_data_valid) begin
          m0_rd_data_valid = (r_owner == 1'b0);
          m1_rd_data_valid = (r_owner == 1'b1);
          if (r_beat_cnt == c_last_beat) w_state_nxt    = IDLE;
          else                           w_beat_cnt_nxt = r_beat_cnt + c_one;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Outputs take their reset values for as long as reset is held
    if (rst) begin
      br_cmd_en        = 1'b0;
      br_cmd           = 1'b0;
      br_addr          = '0;
      br_wr_data       = '0;
      br_data_mask     = '0;
      m0_rd_data_valid = 1'b0;
      m1_rd_data_valid = 1'b0;
    end
  end

endmodule
`default_nettype wire
